sdcard_arbiter: RTL and testbench
=================================

Name: sdcard_arbiter

Overview:
- Shares the single SD-card controller host port (sector address, read/write start/done/ack handshake, 256-word transfer buffers) between two requesters, e.g. two disk-controller emulations.
- Grants exclusive ownership via a req/gnt lock, routes the owner's handshake and buffer traffic to the controller, and blocks everyone else.
- Drains an abandoned or stalled operation so the card side always returns to a clean four-phase idle.
- Sits between the disk controllers and the SD-card controller, in the controller_clk domain.

Parameters:
- TIMEOUT, 24'd5000000: owner inactivity limit in controller_clk cycles before forced release.
- TW, 24: width of the inactivity counter.

Ports:
- controller_clk  in  1  processor-bus clock; single clock of the block.
- reset  in  1  asynchronous, active-high reset.
- rq_req  in  2  per-requester ownership request, level.
- rq_gnt  out  2  per-requester grant, one-hot or zero.
- rq_timeout  out  2  per-requester sticky "forcibly released" flag.
- rq0_addr, rq1_addr  in  27  sector address.
- rq_read_start, rq_write_start, rq_read_ack, rq_write_ack  in  2 each  handshake inputs, bit n belongs to requester n.
- rq_read_done, rq_write_done, rq_error, rq_idle  out  2 each  handshake outputs, valid only for the owner.
- rq0_xfer_addr, rq1_xfer_addr  in  8  buffer word address.
- rq0_xfer_in, rq1_xfer_in  in  16  buffer write data.
- rq_xfer_write  in  2  buffer write strobe.
- rq_xfer_out  out  16  buffer read data, shared bus.
- sd_addr  out  27  to controller.
- sd_read_start, sd_write_start, sd_read_ack, sd_write_ack  out  1 each  to controller.
- sd_read_done, sd_write_done, sd_error, sd_idle  in  1 each  from controller.
- sd_xfer_addr  out  8  to controller.
- sd_xfer_in  out  16  to controller.
- sd_xfer_write  out  1  to controller.
- sd_xfer_out  in  16  from controller.
- owner  out  2  debug: 00 none, 01 rq0, 10 rq1.

Behaviour:
- Reset (async): state FREE, rq_gnt=0, owner=00, rq_timeout=0, rr_last=1 (rq0 wins first tie), counter=0, all sd_* handshake outputs 0.
- States: FREE, OWN, DRAIN_WAIT, DRAIN_ACK.
- FREE:
  - If any rq_req is set, grant on the next edge.
  - On a tie, grant the requester that is not rr_last; set rr_last to the grantee.
  - A single requester is granted regardless of rr_last.
  - Grant latency is 1 cycle from req sampled high.
- OWN:
  - Owner signals pass combinationally to sd_*: addr, start, ack, xfer_addr, xfer_in, xfer_write.
  - sd done/error/idle pass to the owner's bit only; the non-owner sees done=0, error=0, idle=0.
  - rq_xfer_out = sd_xfer_out at all times; the buffer latency is the controller's own.
  - Non-owner xfer_write is ignored.
- Owner drops req:
  - If sd_read_done, sd_write_done and the sd start lines are all 0, go to FREE next cycle.
  - Otherwise go to DRAIN_WAIT.
  - In both cases rq_gnt drops the same edge, and all sd_* drive from arbiter registers (starts held at their last values).
- Inactivity counter:
  - Cleared on grant and on any change of owner start/ack, owner xfer_write, or sd done.
  - Increments otherwise in OWN.
  - At TIMEOUT-1: set the owner's rq_timeout, drop gnt, go to DRAIN_WAIT.
  - Saturates; no wrap.
- DRAIN_WAIT:
  - Hold the latched start until sd_read_done or sd_write_done is 1.
  - If no start was active and no done is pending, go straight to FREE.
  - On done: drop start, assert the matching sd ack, go to DRAIN_ACK.
- DRAIN_ACK:
  - When sd_*_done returns to 0, drop ack and go to FREE.
  - If the controller raises done while no start is latched, ack it anyway.
- rq_timeout[n] clears when rq_req[n] is low.
- A requester is not re-granted while its rq_timeout is set.
- rq_req from the other requester during OWN/DRAIN is held pending; it is granted on the first FREE cycle.
- Simultaneous owner req-drop and timeout: the req-drop wins and rq_timeout is not set.
- Reset mid-operation: everything returns immediately to reset values; the controller sees starts/acks fall.

Test Plan:
- rq_req=01 → rq_gnt=01 one cycle later, owner=01. rq0 writes word 16'hA5A5 at xfer_addr 8'h10, write_start; drive sd_write_done=1 → rq_write_done=01. rq0 ack completes the four-phase handshake → sd_xfer_in/addr saw A5A5/10, sd_write_ack followed.
- rq_req=11 from reset → rq0 granted first. rq0 drops → rq1 granted one cycle later. Both re-request → rq0 granted (round-robin).
- rq1 xfer_write while rq0 owns → sd_xfer_write stays 0. rq1 sees rq_read_done=0 while sd_read_done=1.
- rq0 read_start then drops req before done → gnt=00, state DRAIN_WAIT. sd_read_done=1 → sd_read_ack=1. done=0 → ack=0, FREE; rq1 pending request granted next.
- TIMEOUT=16, rq0 granted and silent → at cycle 16 rq_timeout=01, gnt=00. rq0 req stays high → not re-granted. rq0 req low → rq_timeout=00.
- Assert reset during DRAIN_ACK → sd_read_ack=0, rq_gnt=00, owner=00 without waiting for a clock edge.

Source files
------------

// File: rtl/sdcard_arbiter.sv
// Two-requester arbiter for the SD-card controller host port: req/gnt lock,
// owner routing, inactivity release and draining of abandoned card operations.
module sdcard_arbiter #(
    parameter int            TW      = 24,
    parameter logic [TW-1:0] TIMEOUT = 24'd5000000
) (
    input  logic        controller_clk,
    input  logic        reset,
    input  logic [1:0]  rq_req,
    output logic [1:0]  rq_gnt,
    output logic [1:0]  rq_timeout,
    input  logic [26:0] rq0_addr,
    input  logic [26:0] rq1_addr,
    input  logic [1:0]  rq_read_start,
    input  logic [1:0]  rq_write_start,
    input  logic [1:0]  rq_read_ack,
    input  logic [1:0]  rq_write_ack,
    output logic [1:0]  rq_read_done,
    output logic [1:0]  rq_write_done,
    output logic [1:0]  rq_error,
    output logic [1:0]  rq_idle,
    input  logic [7:0]  rq0_xfer_addr,
    input  logic [7:0]  rq1_xfer_addr,
    input  logic [15:0] rq0_xfer_in,
    input  logic [15:0] rq1_xfer_in,
    input  logic [1:0]  rq_xfer_write,
    output logic [15:0] rq_xfer_out,
    output logic [26:0] sd_addr,
    output logic        sd_read_start,
    output logic        sd_write_start,
    output logic        sd_read_ack,
    output logic        sd_write_ack,
    input  logic        sd_read_done,
    input  logic        sd_write_done,
    input  logic        sd_error,
    input  logic        sd_idle,
    output logic [7:0]  sd_xfer_addr,
    output logic [15:0] sd_xfer_in,
    output logic        sd_xfer_write,
    input  logic [15:0] sd_xfer_out,
    output logic [1:0]  owner
);

    typedef enum logic [1:0] {
        FREE       = 2'd0,
        OWN        = 2'd1,
        DRAIN_WAIT = 2'd2,
        DRAIN_ACK  = 2'd3
    } state_t;

    localparam logic [TW-1:0] CNT_LAST = TIMEOUT - {{(TW-1){1'b0}}, 1'b1};
    localparam logic [TW-1:0] CNT_MAX  = {TW{1'b1}};

    state_t        state_r, state_next_s;
    logic [1:0]    gnt_r, gnt_next_s;
    logic [1:0]    tmo_r, tmo_next_s;
    logic          rr_last_r, rr_next_s;
    logic [TW-1:0] cnt_r, cnt_next_s;
    logic [6:0]    prev_act_r, act_s;
    logic [26:0]   hold_addr_r, hold_addr_next_s;
    logic [7:0]    hold_xaddr_r, hold_xaddr_next_s;
    logic [15:0]   hold_xin_r, hold_xin_next_s;
    logic          hold_rs_r, hold_ws_r, hold_ra_r, hold_wa_r;
    logic          hold_rs_next_s, hold_ws_next_s, hold_ra_next_s, hold_wa_next_s;

    logic [1:0]    elig_s;
    logic          grant_idx_s, own_idx_s, act_idx_s, sd_done_s;
    logic [26:0]   own_addr_s;
    logic [7:0]    own_xaddr_s;
    logic [15:0]   own_xin_s;

    assign own_idx_s   = gnt_r[1];
    assign own_addr_s  = own_idx_s ? rq1_addr      : rq0_addr;
    assign own_xaddr_s = own_idx_s ? rq1_xfer_addr : rq0_xfer_addr;
    assign own_xin_s   = own_idx_s ? rq1_xfer_in   : rq0_xfer_in;
    assign sd_done_s   = sd_read_done | sd_write_done;
    assign elig_s      = rq_req & ~tmo_r;

    // Requester selection in FREE: alternate on a tie, otherwise the lone eligible one
    always_comb begin
        grant_idx_s = 1'b0;
        if (elig_s == 2'b11) begin
            grant_idx_s = ~rr_last_r;
        end else begin
            grant_idx_s = elig_s[1];
        end
    end

    // Activity snapshot of whoever owns (or is about to own) the port
    always_comb begin
        act_idx_s = (state_r == OWN) ? own_idx_s : grant_idx_s;
        act_s = {rq_read_start[act_idx_s], rq_write_start[act_idx_s],
                 rq_read_ack[act_idx_s], rq_write_ack[act_idx_s],
                 rq_xfer_write[act_idx_s], sd_read_done, sd_write_done};
    end

    // Port routing: live owner signals while owned, arbiter registers otherwise
    always_comb begin
        rq_read_done  = 2'b00;
        rq_write_done = 2'b00;
        rq_error      = 2'b00;
        rq_idle       = 2'b00;
        if (state_r == OWN) begin
            sd_addr        = own_addr_s;
            sd_xfer_addr   = own_xaddr_s;
            sd_xfer_in     = own_xin_s;
            sd_xfer_write  = rq_xfer_write[own_idx_s];
            sd_read_start  = rq_read_start[own_idx_s];
            sd_write_start = rq_write_start[own_idx_s];
            sd_read_ack    = rq_read_ack[own_idx_s];
            sd_write_ack   = rq_write_ack[own_idx_s];
            rq_read_done[own_idx_s]  = sd_read_done;
            rq_write_done[own_idx_s] = sd_write_done;
            rq_error[own_idx_s]      = sd_error;
            rq_idle[own_idx_s]       = sd_idle;
        end else begin
            sd_addr        = hold_addr_r;
            sd_xfer_addr   = hold_xaddr_r;
            sd_xfer_in     = hold_xin_r;
            sd_xfer_write  = 1'b0;
            sd_read_start  = hold_rs_r;
            sd_write_start = hold_ws_r;
            sd_read_ack    = hold_ra_r;
            sd_write_ack   = hold_wa_r;
        end
    end

    assign rq_xfer_out = sd_xfer_out;
    assign rq_gnt      = gnt_r;
    assign owner       = gnt_r;
    assign rq_timeout  = tmo_r;

    // Next-state, grant, inactivity counter and drain register updates
    always_comb begin
        state_next_s      = state_r;
        gnt_next_s        = gnt_r;
        rr_next_s         = rr_last_r;
        cnt_next_s        = cnt_r;
        tmo_next_s        = tmo_r & rq_req;
        hold_addr_next_s  = hold_addr_r;
        hold_xaddr_next_s = hold_xaddr_r;
        hold_xin_next_s   = hold_xin_r;
        hold_rs_next_s    = hold_rs_r;
        hold_ws_next_s    = hold_ws_r;
        hold_ra_next_s    = hold_ra_r;
        hold_wa_next_s    = hold_wa_r;
        case (state_r)
            FREE: begin
                hold_rs_next_s = 1'b0;
                hold_ws_next_s = 1'b0;
                hold_ra_next_s = 1'b0;
                hold_wa_next_s = 1'b0;
                if (elig_s != 2'b00) begin
                    state_next_s = OWN;
                    gnt_next_s   = grant_idx_s ? 2'b10 : 2'b01;
                    rr_next_s    = grant_idx_s;
                    cnt_next_s   = {TW{1'b0}};
                end else begin
                    gnt_next_s = 2'b00;
                end
            end
            OWN: begin
                // Snapshot so the card side holds steady once the owner goes away
                hold_addr_next_s  = own_addr_s;
                hold_xaddr_next_s = own_xaddr_s;
                hold_xin_next_s   = own_xin_s;
                hold_rs_next_s    = rq_read_start[own_idx_s];
                hold_ws_next_s    = rq_write_start[own_idx_s];
                hold_ra_next_s    = rq_read_ack[own_idx_s];
                hold_wa_next_s    = rq_write_ack[own_idx_s];
                if (!rq_req[own_idx_s]) begin
                    gnt_next_s = 2'b00;
                    if (!sd_done_s && !rq_read_start[own_idx_s] && !rq_write_start[own_idx_s]) begin
                        state_next_s = FREE;
                    end else begin
                        state_next_s = DRAIN_WAIT;
                    end
                end else if (act_s != prev_act_r) begin
                    cnt_next_s = {TW{1'b0}};
                end else if (cnt_r == CNT_LAST) begin
                    tmo_next_s[own_idx_s] = 1'b1;
                    gnt_next_s            = 2'b00;
                    state_next_s          = DRAIN_WAIT;
                end else if (cnt_r != CNT_MAX) begin
                    cnt_next_s = cnt_r + {{(TW-1){1'b0}}, 1'b1};
                end else begin
                    cnt_next_s = cnt_r;
                end
            end
            DRAIN_WAIT: begin
                if (sd_done_s) begin
                    hold_rs_next_s = 1'b0;
                    hold_ws_next_s = 1'b0;
                    hold_ra_next_s = sd_read_done;
                    hold_wa_next_s = sd_write_done;
                    state_next_s   = DRAIN_ACK;
                end else if (!hold_rs_r && !hold_ws_r) begin
                    hold_ra_next_s = 1'b0;
                    hold_wa_next_s = 1'b0;
                    state_next_s   = FREE;
                end else begin
                    state_next_s = DRAIN_WAIT;
                end
            end
            DRAIN_ACK: begin
                if (!sd_done_s) begin
                    hold_ra_next_s = 1'b0;
                    hold_wa_next_s = 1'b0;
                    state_next_s   = FREE;
                end else begin
                    hold_ra_next_s = hold_ra_r | sd_read_done;
                    hold_wa_next_s = hold_wa_r | sd_write_done;
                end
            end
            default: begin
                state_next_s = FREE;
                gnt_next_s   = 2'b00;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge controller_clk or posedge reset) begin
        if (reset) begin
            state_r      <= FREE;
            gnt_r        <= 2'b00;
            tmo_r        <= 2'b00;
            rr_last_r    <= 1'b1;
            cnt_r        <= {TW{1'b0}};
            prev_act_r   <= 7'd0;
            hold_addr_r  <= 27'd0;
            hold_xaddr_r <= 8'd0;
            hold_xin_r   <= 16'd0;
            hold_rs_r    <= 1'b0;
            hold_ws_r    <= 1'b0;
            hold_ra_r    <= 1'b0;
            hold_wa_r    <= 1'b0;
        end else begin
            state_r      <= state_next_s;
            gnt_r        <= gnt_next_s;
            tmo_r        <= tmo_next_s;
            rr_last_r    <= rr_next_s;
            cnt_r        <= cnt_next_s;
            prev_act_r   <= act_s;
            hold_addr_r  <= hold_addr_next_s;
            hold_xaddr_r <= hold_xaddr_next_s;
            hold_xin_r   <= hold_xin_next_s;
            hold_rs_r    <= hold_rs_next_s;
            hold_ws_r    <= hold_ws_next_s;
            hold_ra_r    <= hold_ra_next_s;
            hold_wa_r    <= hold_wa_next_s;
        end
    end

endmodule

// File: tb/tb_sdcard_arbiter.sv
// Directed self-checking bench for sdcard_arbiter with a short inactivity limit.
module tb_sdcard_arbiter;

    logic        controller_clk = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  rq_req = 2'b00;
    logic [1:0]  rq_gnt, rq_timeout;
    logic [26:0] rq0_addr = 27'd0, rq1_addr = 27'd0;
    logic [1:0]  rq_read_start = 2'b00, rq_write_start = 2'b00;
    logic [1:0]  rq_read_ack = 2'b00, rq_write_ack = 2'b00;
    logic [1:0]  rq_read_done, rq_write_done, rq_error, rq_idle;
    logic [7:0]  rq0_xfer_addr = 8'd0, rq1_xfer_addr = 8'd0;
    logic [15:0] rq0_xfer_in = 16'd0, rq1_xfer_in = 16'd0;
    logic [1:0]  rq_xfer_write = 2'b00;
    logic [15:0] rq_xfer_out;
    logic [26:0] sd_addr;
    logic        sd_read_start, sd_write_start, sd_read_ack, sd_write_ack;
    logic        sd_read_done = 1'b0, sd_write_done = 1'b0, sd_error = 1'b0, sd_idle = 1'b0;
    logic [7:0]  sd_xfer_addr;
    logic [15:0] sd_xfer_in;
    logic        sd_xfer_write;
    logic [15:0] sd_xfer_out = 16'd0;
    logic [1:0]  owner;

    int checks = 0;
    int failures = 0;

    sdcard_arbiter #(.TW(24), .TIMEOUT(24'd16)) dut (
        .controller_clk(controller_clk), .reset(reset),
        .rq_req(rq_req), .rq_gnt(rq_gnt), .rq_timeout(rq_timeout),
        .rq0_addr(rq0_addr), .rq1_addr(rq1_addr),
        .rq_read_start(rq_read_start), .rq_write_start(rq_write_start),
        .rq_read_ack(rq_read_ack), .rq_write_ack(rq_write_ack),
        .rq_read_done(rq_read_done), .rq_write_done(rq_write_done),
        .rq_error(rq_error), .rq_idle(rq_idle),
        .rq0_xfer_addr(rq0_xfer_addr), .rq1_xfer_addr(rq1_xfer_addr),
        .rq0_xfer_in(rq0_xfer_in), .rq1_xfer_in(rq1_xfer_in),
        .rq_xfer_write(rq_xfer_write), .rq_xfer_out(rq_xfer_out),
        .sd_addr(sd_addr), .sd_read_start(sd_read_start), .sd_write_start(sd_write_start),
        .sd_read_ack(sd_read_ack), .sd_write_ack(sd_write_ack),
        .sd_read_done(sd_read_done), .sd_write_done(sd_write_done),
        .sd_error(sd_error), .sd_idle(sd_idle),
        .sd_xfer_addr(sd_xfer_addr), .sd_xfer_in(sd_xfer_in), .sd_xfer_write(sd_xfer_write),
        .sd_xfer_out(sd_xfer_out), .owner(owner)
    );

    always #5 controller_clk = ~controller_clk;

    task automatic step();
        @(posedge controller_clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
        step();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #3;
        checks++; if (rq_gnt !== 2'b00) begin failures++; $display("FAIL reset_gnt got=%b exp=00", rq_gnt); end
        checks++; if (owner !== 2'b00) begin failures++; $display("FAIL reset_owner got=%b exp=00", owner); end
        checks++; if (rq_timeout !== 2'b00) begin failures++; $display("FAIL reset_timeout got=%b exp=00", rq_timeout); end
        checks++; if ({sd_read_start, sd_write_start, sd_read_ack, sd_write_ack} !== 4'b0000) begin failures++; $display("FAIL reset_sd_hs got=%b exp=0000", {sd_read_start, sd_write_start, sd_read_ack, sd_write_ack}); end
        step();
        reset = 1'b0;
        step();
    endtask

    task automatic test_single_write();
        rq_req = 2'b01;
        #1;
        checks++; if (rq_gnt !== 2'b00) begin failures++; $display("FAIL grant_latency got=%b exp=00", rq_gnt); end
        step();
        checks++; if (rq_gnt !== 2'b01) begin failures++; $display("FAIL grant_rq0 got=%b exp=01", rq_gnt); end
        checks++; if (owner !== 2'b01) begin failures++; $display("FAIL owner_rq0 got=%b exp=01", owner); end
        rq0_xfer_addr = 8'h10; rq0_xfer_in = 16'hA5A5; rq_xfer_write = 2'b01;
        #1;
        checks++; if ({sd_xfer_write, sd_xfer_addr, sd_xfer_in} !== {1'b1, 8'h10, 16'hA5A5}) begin failures++; $display("FAIL xfer_route got=%b/%h/%h exp=1/10/a5a5", sd_xfer_write, sd_xfer_addr, sd_xfer_in); end
        step();
        rq_xfer_write = 2'b00; rq_write_start = 2'b01;
        #1;
        checks++; if (sd_write_start !== 1'b1) begin failures++; $display("FAIL write_start_route got=%b exp=1", sd_write_start); end
        step();
        sd_write_done = 1'b1;
        #1;
        checks++; if (rq_write_done !== 2'b01) begin failures++; $display("FAIL write_done_route got=%b exp=01", rq_write_done); end
        rq_write_start = 2'b00; rq_write_ack = 2'b01;
        #1;
        checks++; if ({sd_write_start, sd_write_ack} !== 2'b01) begin failures++; $display("FAIL write_ack_route got=%b exp=01", {sd_write_start, sd_write_ack}); end
        step();
        sd_write_done = 1'b0;
        step();
        rq_write_ack = 2'b00;
        #1;
        checks++; if (sd_write_ack !== 1'b0) begin failures++; $display("FAIL write_ack_drop got=%b exp=0", sd_write_ack); end
        rq_req = 2'b00;
        step();
        checks++; if (rq_gnt !== 2'b00) begin failures++; $display("FAIL release_clean got=%b exp=00", rq_gnt); end
        step();
    endtask

    task automatic test_round_robin();
        do_reset();
        rq_req = 2'b11;
        step();
        checks++; if (rq_gnt !== 2'b01) begin failures++; $display("FAIL rr_first got=%b exp=01", rq_gnt); end
        rq_req = 2'b10;
        step();
        checks++; if (rq_gnt !== 2'b00) begin failures++; $display("FAIL rr_release got=%b exp=00", rq_gnt); end
        step();
        checks++; if (rq_gnt !== 2'b10) begin failures++; $display("FAIL rr_second got=%b exp=10", rq_gnt); end
        rq_req = 2'b00;
        step();
        rq_req = 2'b11;
        step();
        checks++; if (rq_gnt !== 2'b01) begin failures++; $display("FAIL rr_third got=%b exp=01", rq_gnt); end
    endtask

    task automatic test_isolation();
        rq_xfer_write = 2'b10; rq1_xfer_addr = 8'h33;
        sd_read_done = 1'b1; sd_xfer_out = 16'h1234;
        #1;
        checks++; if (sd_xfer_write !== 1'b0) begin failures++; $display("FAIL nonowner_xfer_write got=%b exp=0", sd_xfer_write); end
        checks++; if (rq_read_done !== 2'b01) begin failures++; $display("FAIL nonowner_read_done got=%b exp=01", rq_read_done); end
        checks++; if (rq_xfer_out !== 16'h1234) begin failures++; $display("FAIL xfer_out_bus got=%h exp=1234", rq_xfer_out); end
        rq_xfer_write = 2'b00; sd_read_done = 1'b0; rq_req = 2'b00;
        step();
        step();
    endtask

    task automatic test_drain();
        rq_req = 2'b01;
        step();
        rq_read_start = 2'b01;
        step();
        rq_req = 2'b10;
        step();
        rq_read_start = 2'b00;
        #1;
        checks++; if (rq_gnt !== 2'b00) begin failures++; $display("FAIL drain_gnt got=%b exp=00", rq_gnt); end
        checks++; if (sd_read_start !== 1'b1) begin failures++; $display("FAIL drain_hold_start got=%b exp=1", sd_read_start); end
        step();
        sd_read_done = 1'b1;
        #1;
        checks++; if (rq_read_done !== 2'b00) begin failures++; $display("FAIL drain_done_hidden got=%b exp=00", rq_read_done); end
        step();
        checks++; if ({sd_read_start, sd_read_ack} !== 2'b01) begin failures++; $display("FAIL drain_ack got=%b exp=01", {sd_read_start, sd_read_ack}); end
        sd_read_done = 1'b0;
        step();
        checks++; if ({sd_read_ack, rq_gnt} !== 3'b000) begin failures++; $display("FAIL drain_free got=%b exp=000", {sd_read_ack, rq_gnt}); end
        step();
        checks++; if (rq_gnt !== 2'b10) begin failures++; $display("FAIL pending_grant got=%b exp=10", rq_gnt); end
        rq_req = 2'b00;
        step();
        step();
    endtask

    task automatic test_timeout();
        rq_req = 2'b01;
        step();
        checks++; if (rq_gnt !== 2'b01) begin failures++; $display("FAIL tmo_grant got=%b exp=01", rq_gnt); end
        for (int i = 0; i < 15; i++) step();
        checks++; if ({rq_timeout, rq_gnt} !== 4'b0001) begin failures++; $display("FAIL tmo_early got=%b exp=0001", {rq_timeout, rq_gnt}); end
        step();
        checks++; if ({rq_timeout, rq_gnt} !== 4'b0100) begin failures++; $display("FAIL tmo_fire got=%b exp=0100", {rq_timeout, rq_gnt}); end
        for (int i = 0; i < 4; i++) step();
        checks++; if ({rq_timeout, rq_gnt} !== 4'b0100) begin failures++; $display("FAIL tmo_no_regrant got=%b exp=0100", {rq_timeout, rq_gnt}); end
        rq_req = 2'b00;
        step();
        checks++; if (rq_timeout !== 2'b00) begin failures++; $display("FAIL tmo_clear got=%b exp=00", rq_timeout); end
        rq_req = 2'b01;
        step();
        checks++; if (rq_gnt !== 2'b01) begin failures++; $display("FAIL tmo_regrant got=%b exp=01", rq_gnt); end
        rq_req = 2'b00;
        step();
        step();
    endtask

    task automatic test_reset_in_drain();
        rq_req = 2'b01;
        step();
        rq_read_start = 2'b01;
        step();
        rq_req = 2'b00;
        step();
        rq_read_start = 2'b00;
        sd_read_done = 1'b1;
        step();
        checks++; if (sd_read_ack !== 1'b1) begin failures++; $display("FAIL pre_reset_ack got=%b exp=1", sd_read_ack); end
        #2;
        reset = 1'b1;
        #1;
        checks++; if ({sd_read_ack, rq_gnt, owner} !== 5'b00000) begin failures++; $display("FAIL async_reset got=%b exp=00000", {sd_read_ack, rq_gnt, owner}); end
        sd_read_done = 1'b0;
        step();
        reset = 1'b0;
        step();
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_round_robin();
        test_isolation();
        test_drain();
        test_timeout();
        test_reset_in_drain();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
